conv_column_feeder: RTL

//  Source side of the 3x3 convolver column interface. Accepts a raster pixel stream and an optional kernel.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 32 +++
 rtl/conv_column_feeder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolver column feeder: default pixel width,
// FSM state encodings and the push index at which a window becomes complete.
package conv_pkg;

   localparam int BIT_LEN_DEF = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_KLOAD  = 3'd1;
   localparam logic [2:0] ST_FILL   = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_FLUSH  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   localparam int unsigned TAG_THRESH = 3;

   // A push is tagged once three columns have filled the convolver's window.
   function automatic logic isTagged(input int unsigned k);
      return (k >= TAG_THRESH);
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-line pixel store: each word holds {line r-1, line r-2} for one column.
// Combinational read, synchronous write that shifts the column up by one line.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int BIT_LEN = BIT_LEN_DEF,
   parameter int MAX_W   = 640,
   parameter int ADDR_W  = 10
)(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [BIT_LEN-1:0] i_pix,
   output logic [BIT_LEN-1:0] o_lb0,
   output logic [BIT_LEN-1:0] o_lb1
);

   logic [2*BIT_LEN-1:0] r_mem [MAX_W];
   logic [2*BIT_LEN-1:0] w_word;

   assign w_word = r_mem[i_addr];
   assign o_lb0  = w_word[BIT_LEN-1:0];
   assign o_lb1  = w_word[2*BIT_LEN-1:BIT_LEN];

   // Old line r-1 drops to r-2 while the new pixel becomes line r-1.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= {i_pix, w_word[2*BIT_LEN-1:BIT_LEN]};
      end
   end

endmodule

// File: rtl/conv_column_feeder.sv
// Source side of the 3x3 convolver column interface: line buffering, kernel
// loading, per-row flush column and result tagging. Kernel load needs CONV_FEEDER_KLOAD_EN.
module conv_column_feeder
   import conv_pkg::*;
#(
   parameter int BIT_LEN = BIT_LEN_DEF,
   parameter int MAX_W   = 640,
   parameter int ADDR_W  = 10,
   parameter int DIM_W   = 11
)(
   input  logic                 CLK100MHZ,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [DIM_W-1:0]     i_width,
   input  logic [DIM_W-1:0]     i_height,
   input  logic [3*BIT_LEN-1:0] i_k_data,
   input  logic                 i_k_valid,
   output logic                 o_k_ready,
   input  logic [BIT_LEN-1:0]   i_pix,
   input  logic                 i_pix_valid,
   output logic                 o_pix_ready,
   output logic [BIT_LEN-1:0]   o_dato0,
   output logic [BIT_LEN-1:0]   o_dato1,
   output logic [BIT_LEN-1:0]   o_dato2,
   output logic                 o_selecK_I,
   output logic                 o_valid,
   output logic                 o_res_valid,
   output logic                 o_busy,
   output logic                 o_done
);

   logic [2:0]         r_state;
   logic [ADDR_W-1:0]  r_col;
   logic [DIM_W-1:0]   r_row;
   logic [DIM_W-1:0]   r_width;
   logic [DIM_W-1:0]   r_height;
   logic               r_valid;
   logic               r_selecK_I;
   logic               r_tag;
   logic               r_res_valid;
   logic               r_done;
   logic [BIT_LEN-1:0] r_dato0;
   logic [BIT_LEN-1:0] r_dato1;
   logic [BIT_LEN-1:0] r_dato2;
`ifdef CONV_FEEDER_KLOAD_EN
   logic [1:0]         r_kCount;
`endif

   logic               w_pixAccept;
   logic [BIT_LEN-1:0] w_lb0;
   logic [BIT_LEN-1:0] w_lb1;
   logic               w_lastCol;
   logic               w_lastRow;
   logic               w_pixTag;
   logic               w_flushTag;

   assign o_pix_ready = (r_state == ST_FILL) || (r_state == ST_STREAM);
   assign w_pixAccept = i_pix_valid && o_pix_ready;
   assign w_lastCol   = (r_col == ADDR_W'(r_width - 1'b1));
   assign w_lastRow   = (r_row == r_height - 1'b1);
   assign w_pixTag    = isTagged(32'(r_col));
   assign w_flushTag  = isTagged(32'(r_width));

`ifdef CONV_FEEDER_KLOAD_EN
   assign o_k_ready = (r_state == ST_KLOAD);
`else
   logic w_unused;
   assign o_k_ready = 1'b0;
   assign w_unused  = ^{i_k_data, i_k_valid};
`endif

   assign o_dato0     = r_dato0;
   assign o_dato1     = r_dato1;
   assign o_dato2     = r_dato2;
   assign o_selecK_I  = r_selecK_I;
   assign o_valid     = r_valid;
   assign o_res_valid = r_res_valid;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = r_done;

   conv_line_buffer #(
      .BIT_LEN (BIT_LEN),
      .MAX_W   (MAX_W),
      .ADDR_W  (ADDR_W)
   ) u_lineBuffer (
      .i_clk  (CLK100MHZ),
      .i_we   (w_pixAccept),
      .i_addr (r_col),
      .i_pix  (i_pix),
      .o_lb0  (w_lb0),
      .o_lb1  (w_lb1)
   );

   // Push strobe, tag and done are single-cycle pulses; the result flag trails a tagged push by one cycle.
   always_ff @(posedge CLK100MHZ or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_width     <= '0;
         r_height    <= '0;
         r_valid     <= 1'b0;
         r_selecK_I  <= 1'b0;
         r_tag       <= 1'b0;
         r_res_valid <= 1'b0;
         r_done      <= 1'b0;
         r_dato0     <= '0;
         r_dato1     <= '0;
         r_dato2     <= '0;
`ifdef CONV_FEEDER_KLOAD_EN
         r_kCount    <= '0;
`endif
      end else begin
         r_valid     <= 1'b0;
         r_tag       <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= r_valid && r_tag;

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_width  <= i_width;
                  r_height <= i_height;
                  r_col    <= '0;
                  r_row    <= '0;
`ifdef CONV_FEEDER_KLOAD_EN
                  r_kCount <= '0;
                  r_state  <= ST_KLOAD;
`else
                  r_state  <= ST_FILL;
`endif
               end
            end

`ifdef CONV_FEEDER_KLOAD_EN
            ST_KLOAD: begin
               if (i_k_valid) begin
                  r_valid    <= 1'b1;
                  r_selecK_I <= 1'b0;
                  r_dato0    <= i_k_data[BIT_LEN-1:0];
                  r_dato1    <= i_k_data[2*BIT_LEN-1:BIT_LEN];
                  r_dato2    <= i_k_data[3*BIT_LEN-1:2*BIT_LEN];
                  if (r_kCount == 2'd2) begin
                     r_kCount <= '0;
                     r_state  <= ST_FILL;
                  end else begin
                     r_kCount <= r_kCount + 2'd1;
                  end
               end
            end
`endif

            // The first two rows only prime the line buffer.
            ST_FILL: begin
               if (w_pixAccept) begin
                  if (w_lastCol) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                     if (r_row == DIM_W'(1)) begin
                        r_state <= ST_STREAM;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end

            ST_STREAM: begin
               if (w_pixAccept) begin
                  r_valid    <= 1'b1;
                  r_selecK_I <= 1'b1;
                  r_tag      <= w_pixTag;
                  r_dato0    <= w_lb0;
                  r_dato1    <= w_lb1;
                  r_dato2    <= i_pix;
                  if (w_lastCol) begin
                     r_col   <= '0;
                     r_state <= ST_FLUSH;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end

            // A zero column pushes the last complete window out of the convolver.
            ST_FLUSH: begin
               r_valid    <= 1'b1;
               r_selecK_I <= 1'b1;
               r_tag      <= w_flushTag;
               r_dato0    <= '0;
               r_dato1    <= '0;
               r_dato2    <= '0;
               if (w_lastRow) begin
                  r_row   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_row   <= r_row + 1'b1;
                  r_state <= ST_STREAM;
               end
            end

            // First DONE cycle shows the final flush push, the second raises o_done.
            ST_DONE: begin
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
